alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Sequential front-end for the 4-bit ALU on the FPGA board. It collects A, B and the operation code one at a time from four slide switches, using a debounced ENTER button. It then drives the ALU's `seletor`/`A`/`B` inputs, captures the combinational result into a register, and holds it for display. A debounced CLEAR button aborts the sequence from any state.

## Interface
Parameters:
- `DEBOUNCE_CYC`, default 500000: cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz). The bench uses 4.

Ports:
- `clk`  in  1  system clock; every register is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `sw`  in  4  raw slide switches; data/opcode source. Quasi-static, sampled directly.
- `btn_enter`  in  1  raw ENTER button, active-high, asynchronous, bouncy.
- `btn_clear`  in  1  raw CLEAR button, active-high, asynchronous, bouncy.
- `alu_S`  in  4  result returned from the ALU.
- `A`  out  4  operand A to the ALU.
- `B`  out  4  operand B to the ALU.
- `seletor`  out  3  operation code to the ALU.
- `result`  out  4  registered ALU result.
- `result_valid`  out  1  high while `result` holds a fresh computation.
- `zero`  out  1  registered `(alu_S == 0)`, captured together with `result`.
- `estado`  out  3  current FSM state, for LEDs.

## Operation
- Each button passes through a 2-flop synchronizer, then a stability counter of `DEBOUNCE_CYC` cycles, then a rising-edge detector. This yields a 1-cycle pulse: `enter_p` or `clear_p`.
- States and encodings (exported on `estado`):
  - LOAD_A=0: on `enter_p`, `A <= sw`, go to LOAD_B.
  - LOAD_B=1: on `enter_p`, `B <= sw`, go to LOAD_OP.
  - LOAD_OP=2: on `enter_p`, `seletor <= sw[2:0]` (`sw[3]` ignored), go to EXEC.
  - EXEC=3: unconditional, lasts exactly 1 cycle. `result <= alu_S`, `zero <= (alu_S==0)`, `result_valid <= 1`, go to SHOW.
  - SHOW=4: outputs hold. On `enter_p`: `result_valid <= 0`, go to LOAD_A. `A`/`B`/`seletor` are kept until overwritten.
  - Encodings 5–7 are illegal. They go to LOAD_A on the next clock with all data registers cleared.
- `clear_p` in any state: go to LOAD_A and set `A`, `B`, `seletor`, `result`, `zero`, `result_valid` to 0.
- If `clear_p` and `enter_p` occur in the same cycle, `clear_p` wins and `enter_p` is dropped.
- Arithmetic is performed only by the ALU. This block stores `alu_S` unmodified, so wrap-around (e.g. 3−5=14) is passed through.
- If the switches change after a load, the stored operands are unaffected.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n`=0):
  - State LOAD_A, `estado`=0.
  - `A`=`B`=0, `seletor`=0, `result`=0, `zero`=0, `result_valid`=0.
  - Synchronizer flops, debounced levels and counters all 0.
- Reset in the middle of an operation discards all progress. No pulse is generated on release if a button is held across reset: the debounced level must first be seen low.
- Button latency: 2 sync cycles + `DEBOUNCE_CYC` stable cycles + 1 edge cycle, then `enter_p` is high for exactly 1 cycle.
- A bounce shorter than `DEBOUNCE_CYC` restarts the counter and produces no pulse. One press gives exactly one pulse, however long it is held.
- A register update triggered by `enter_p` in cycle N is visible in cycle N+1.
- Entering EXEC at cycle N gives `result`/`zero`/`result_valid` valid at N+1. The ALU has one full cycle of settling before capture.

## Structure
- Shared package/include `alu_pkg` holds:
  - State localparams LOAD_A..SHOW.
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_SHL=2, OP_SHR=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_NOT=7.
  - Data width 4.
- One sub-module, `button_debouncer`, containing synchronizer, counter and edge detector. It has parameter `DEBOUNCE_CYC`, ports (`clk`, `rst_n`, `btn_raw`, `pulse`), and is instantiated twice.
- The ALU itself is instantiated only in the board top level, not inside this block.

## Test plan
- Add: `sw`=5, ENTER; `sw`=3, ENTER; `sw`=0, ENTER; ALU model connected. Expect EXEC for 1 cycle, then `result`=8, `zero`=0, `result_valid`=1, `estado`=4.
- Subtract wrap: A=3, B=5, op=1. Expect `result`=14. Then A=4, B=4, op=1: expect `result`=0, `zero`=1.
- Debounce: a 2-cycle glitch on `btn_enter` produces no state change. A 20-cycle press with 3 bounces at its start produces exactly one `enter_p`, and the state advances by exactly one.
- CLEAR in LOAD_OP after A=7, B=2: expect `estado`=0 and `A`=`B`=`seletor`=0. Pressing CLEAR and ENTER together: CLEAR wins.
- `rst_n` pulsed low for half a cycle while in EXEC: outputs go to reset values immediately, `result_valid` stays 0, and the FSM restarts in LOAD_A.
- SHOW then ENTER: `result_valid` falls the next cycle, and `A`/`B`/`seletor` keep their previous values until the next loads.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand loader: FSM states, ALU opcodes, data width.
package alu_pkg;

    localparam int unsigned DATA_W = 4;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> stability counter -> one-cycle rising-edge pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync0_q, sync1_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             armed_q, armed_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        armed_d = armed_q;
        pulse_d = 1'b0;
        // Until a debounced low is seen, a button held through reset must not fire.
        if (!armed_q) begin
            if (sync1_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                armed_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (sync1_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync1_q;
            cnt_d   = '0;
            pulse_d = sync1_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync0_q <= btn_raw;
            sync1_q <= sync0_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequential front-end for the 4-bit ALU: loads A, B and opcode from switches, captures the result.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_enter,
    input  logic              btn_clear,
    input  logic [DATA_W-1:0] alu_S,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [2:0]        seletor,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              zero,
    output logic [2:0]        estado
);

    logic enter_p, clear_p;

    button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_enter (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_enter),
        .pulse   (enter_p)
    );

    button_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_clear),
        .pulse   (clear_p)
    );

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]        sel_q, sel_d;
    logic              zero_q, zero_d, valid_q, valid_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = valid_q;
        if (clear_p) begin
            state_d  = LOAD_A;
            a_d      = '0;
            b_d      = '0;
            sel_d    = '0;
            result_d = '0;
            zero_d   = 1'b0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: if (enter_p) begin
                    a_d     = sw;
                    state_d = LOAD_B;
                end
                LOAD_B: if (enter_p) begin
                    b_d     = sw;
                    state_d = LOAD_OP;
                end
                LOAD_OP: if (enter_p) begin
                    sel_d   = sw[2:0];
                    state_d = EXEC;
                end
                EXEC: begin
                    result_d = alu_S;
                    zero_d   = (alu_S == '0);
                    valid_d  = 1'b1;
                    state_d  = SHOW;
                end
                SHOW: if (enter_p) begin
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
                default: begin
                    state_d  = LOAD_A;
                    a_d      = '0;
                    b_d      = '0;
                    sel_d    = '0;
                    result_d = '0;
                    zero_d   = 1'b0;
                    valid_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign seletor      = sel_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign result_valid = valid_q;
    assign estado       = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed self-checking bench for alu_operand_loader with a behavioural ALU on alu_S.
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_enter, btn_clear;
    logic [3:0] alu_S, A, B, result;
    logic [2:0] seletor, estado;
    logic       result_valid, zero;

    int checks = 0;
    int errors = 0;
    int exec_cnt = 0;
    int e0;

    always #5 clk = ~clk;

    alu_operand_loader #(.DEBOUNCE_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .alu_S        (alu_S),
        .A            (A),
        .B            (B),
        .seletor      (seletor),
        .result       (result),
        .result_valid (result_valid),
        .zero         (zero),
        .estado       (estado)
    );

    always_comb begin
        case (seletor)
            3'd0:    alu_S = A + B;
            3'd1:    alu_S = A - B;
            3'd2:    alu_S = A << 1;
            3'd3:    alu_S = A >> 1;
            3'd4:    alu_S = A & B;
            3'd5:    alu_S = A | B;
            3'd6:    alu_S = A ^ B;
            default: alu_S = ~A;
        endcase
    end

    always @(negedge clk) if (estado == 3'd3) exec_cnt++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic en, input logic cl, input int hold);
        btn_enter = en;
        btn_clear = cl;
        step(hold);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        step(12);
    endtask

    task automatic load(input logic [3:0] v);
        sw = v;
        press(1'b1, 1'b0, 10);
    endtask

    initial begin
        rst_n = 1'b0;
        sw = 4'd0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        step(2);
        check("rst_estado", estado, 0);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_sel", seletor, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_valid", result_valid, 0);
        rst_n = 1'b1;
        step(10);

        // 5 + 3 = 8
        load(4'd5);
        check("add_A_state", estado, 1);
        check("add_A", A, 5);
        load(4'd3);
        check("add_B_state", estado, 2);
        check("add_B", B, 3);
        e0 = exec_cnt;
        load(4'd0);
        check("add_exec_cycles", 8'(exec_cnt - e0), 1);
        check("add_estado", estado, 4);
        check("add_result", result, 8);
        check("add_zero", zero, 0);
        check("add_valid", result_valid, 1);
        press(1'b1, 1'b0, 10);
        check("show_to_loada", estado, 0);

        // 3 - 5 wraps to 14
        load(4'd3);
        load(4'd5);
        load(4'd9);
        check("sub_sel_sw3_ignored", seletor, 1);
        check("sub_result", result, 14);
        check("sub_zero", zero, 0);

        // leaving SHOW: valid drops with the state change, operands held
        btn_enter = 1'b1;
        for (int i = 0; i < 20 && estado == 3'd4; i++) step(1);
        check("leave_estado", estado, 0);
        check("leave_valid", result_valid, 0);
        check("leave_A", A, 3);
        check("leave_B", B, 5);
        check("leave_sel", seletor, 1);
        check("leave_result_hold", result, 14);
        btn_enter = 1'b0;
        step(12);

        // 4 - 4 = 0
        load(4'd4);
        load(4'd4);
        load(4'd1);
        check("subz_result", result, 0);
        check("subz_zero", zero, 1);
        check("subz_valid", result_valid, 1);
        press(1'b1, 1'b0, 10);

        // 2-cycle glitch: no pulse
        sw = 4'd9;
        btn_enter = 1'b1;
        step(2);
        btn_enter = 1'b0;
        step(12);
        check("glitch_estado", estado, 0);
        check("glitch_A", A, 4);

        // bouncy 20-cycle press: exactly one advance
        for (int i = 0; i < 3; i++) begin
            btn_enter = 1'b1;
            step(1);
            btn_enter = 1'b0;
            step(1);
        end
        press(1'b1, 1'b0, 20);
        check("bounce_estado", estado, 1);
        check("bounce_A", A, 9);
        sw = 4'd15;
        step(3);
        check("sw_change_A", A, 9);

        // CLEAR in LOAD_OP
        press(1'b0, 1'b1, 10);
        check("clr1_estado", estado, 0);
        load(4'd7);
        load(4'd2);
        check("clr_pre_estado", estado, 2);
        press(1'b0, 1'b1, 10);
        check("clr_estado", estado, 0);
        check("clr_A", A, 0);
        check("clr_B", B, 0);
        check("clr_sel", seletor, 0);

        // CLEAR and ENTER together
        load(4'd9);
        check("both_pre_estado", estado, 1);
        press(1'b1, 1'b1, 10);
        check("both_estado", estado, 0);
        check("both_A", A, 0);

        // reset pulse during EXEC with ENTER held through it
        load(4'd1);
        load(4'd2);
        sw = 4'd0;
        btn_enter = 1'b1;
        for (int i = 0; i < 20 && estado != 3'd3; i++) step(1);
        check("reach_exec", estado, 3);
        rst_n = 1'b0;
        #1;
        check("arst_estado", estado, 0);
        check("arst_A", A, 0);
        check("arst_B", B, 0);
        check("arst_result", result, 0);
        check("arst_valid", result_valid, 0);
        #4;
        rst_n = 1'b1;
        step(1);
        check("post_rst_estado", estado, 0);
        check("post_rst_valid", result_valid, 0);
        step(10);
        check("held_no_pulse", estado, 0);
        btn_enter = 1'b0;
        step(12);
        load(4'd6);
        check("after_rst_estado", estado, 1);
        check("after_rst_A", A, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
